ibex_register_file_mp: RTL and testbench

Multi-port flip-flop register file for Ibex-class cores.
- Read-port and write-port counts are parameters.
- Simultaneous writes to the same register are resolved by a defined priority.
- A sequential clear engine re-initialises every architectural register to WordZeroVal without a reset, for context switch and security wipe.
- Sits in the ID stage; write ports are driven from WB and, when present, from a second retire path.

---
 rtl/ibex_register_file_mp.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ibex_register_file_mp.sv | 566 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_register_file_mp.sv
// -----------------------------------------------------------------------------
// ibex_register_file_mp
//
// Multi-port flip-flop register file for an Ibex-class core (ID stage).
// Combinational read ports, write ports that update on the rising edge with a
// fixed highest-port-wins collision rule, and a sequential clear engine that
// rewrites every architectural register to WordZeroVal without a reset.
//
// Ports:
//   clk_i       clock, all state changes on the rising edge
//   rst_i       synchronous, active-high reset
//   raddr_i     read addresses, port k in bits [5k+4:5k]
//   rdata_o     read data, port k in slice k
//   waddr_i     write addresses, port p in bits [5p+4:5p]
//   wdata_i     write data, port p in slice p
//   we_i        per-port write enable
//   clr_req_i   start a clear sequence (only looked at while idle)
//   clr_busy_o  high while the clear engine owns the array
//   clr_done_o  one-cycle pulse when a clear sequence completes
//   err_o       sticky error flag, cleared only by rst_i
//
// Build option:
//   IBEX_RF_BYPASS_EN  when defined, a read of a register that is being
//                      written this cycle returns the incoming write data.
//                      When undefined, reads always return the stored value.
// -----------------------------------------------------------------------------
module ibex_register_file_mp #(
   parameter bit                   RV32E         = 1'b0,
   parameter int unsigned          DataWidth     = 32,
   parameter int unsigned          NumReadPorts  = 2,
   parameter int unsigned          NumWritePorts = 2,
   parameter bit                   WrenCheck     = 1'b0,
   parameter logic [DataWidth-1:0] WordZeroVal   = '0
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NumReadPorts*5-1:0]          raddr_i,
   output logic [NumReadPorts*DataWidth-1:0]  rdata_o,
   input  logic [NumWritePorts*5-1:0]         waddr_i,
   input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
   input  logic [NumWritePorts-1:0]           we_i,
   input  logic                               clr_req_i,
   output logic                               clr_busy_o,
   output logic                               clr_done_o,
   output logic                               err_o
);

   localparam int unsigned NumRegs = RV32E ? 16 : 32;
   localparam logic [4:0]  LastReg = 5'(NumRegs - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_DONE
   } clr_state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   clr_state_e           state_q, state_d;
   logic [4:0]           clr_cnt_q, clr_cnt_d;
   logic                 err_q, err_d;

   // x0 has no storage: the array starts at index 1.
   logic [DataWidth-1:0] rf_q [1:NumRegs-1];
   logic [DataWidth-1:0] rf_d [1:NumRegs-1];

   // ---------------------------------------------------------------------------
   // Port unpacking
   // ---------------------------------------------------------------------------
   logic [4:0]           raddr  [NumReadPorts];
   logic [DataWidth-1:0] rd_val [NumReadPorts];
   logic [4:0]           waddr  [NumWritePorts];
   logic [DataWidth-1:0] wdata  [NumWritePorts];

   // Per-port decoded write enables; bit r set means "port writes xr".
   // Bit 0 is never set, so x0 writes vanish here without an error.
   logic [NumRegs-1:0]   wr_dec [NumWritePorts];

   logic                 wr_allowed;
   logic                 rng_err;
   logic                 wren_err;

   always_comb begin
      for (int k = 0; k < NumReadPorts; k++) begin
         raddr[k] = raddr_i[5*k +: 5];
      end
      for (int p = 0; p < NumWritePorts; p++) begin
         waddr[p] = waddr_i[5*p +: 5];
         wdata[p] = wdata_i[DataWidth*p +: DataWidth];
      end
   end

   // ---------------------------------------------------------------------------
   // Write decode
   // ---------------------------------------------------------------------------
   // In RV32E builds an address with bit 4 set never matches a register index
   // below 16, so out-of-range writes decode to an all-zero vector.
   always_comb begin
      for (int p = 0; p < NumWritePorts; p++) begin
         wr_dec[p] = '0;
         for (int r = 1; r < NumRegs; r++) begin
            wr_dec[p][r] = we_i[p] && (waddr[p] == 5'(r));
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next array contents
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output starts from a full default (here the held
   // value) so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      for (int r = 1; r < NumRegs; r++) begin
         rf_d[r] = rf_q[r];
      end

      // Ports are applied in ascending order so the highest-index port that
      // targets a register is the one that sticks.
      if (wr_allowed) begin
         for (int p = 0; p < NumWritePorts; p++) begin
            for (int r = 1; r < NumRegs; r++) begin
               if (wr_dec[p][r]) begin
                  rf_d[r] = wdata[p];
               end
            end
         end
      end

      // The clear engine wipes one register per cycle.
      if (state_q == ST_CLEAR) begin
         for (int r = 1; r < NumRegs; r++) begin
            if (clr_cnt_q == 5'(r)) begin
               rf_d[r] = WordZeroVal;
            end
         end
      end
   end

   // NOTE: the register array is reset on purpose: x1..xN-1 must come out of
   // reset holding WordZeroVal, so this memory cannot be left uninitialised.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 1; r < NumRegs; r++) begin
            rf_q[r] <= WordZeroVal;
         end
      end else begin
         for (int r = 1; r < NumRegs; r++) begin
            rf_q[r] <= rf_d[r];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------------------
   // x0 and out-of-range addresses match no array entry and read as 0.
   always_comb begin
      rdata_o = '0;
      for (int k = 0; k < NumReadPorts; k++) begin
         rd_val[k] = '0;
         for (int r = 1; r < NumRegs; r++) begin
            if (raddr[k] == 5'(r)) begin
               rd_val[k] = rf_q[r];
            end
         end
`ifdef IBEX_RF_BYPASS_EN
         // Forward this cycle's write data; a non-zero decode vector already
         // implies we=1, a non-x0 target and an in-range address.
         if (wr_allowed) begin
            for (int p = 0; p < NumWritePorts; p++) begin
               if ((|wr_dec[p]) && (waddr[p] == raddr[k])) begin
                  rd_val[k] = wdata[p];
               end
            end
         end
`endif
         rdata_o[DataWidth*k +: DataWidth] = rd_val[k];
      end
   end

   // ---------------------------------------------------------------------------
   // Error detection
   // ---------------------------------------------------------------------------
   // Errors are evaluated regardless of the clear engine state.
   always_comb begin
      rng_err  = 1'b0;
      wren_err = 1'b0;
      if (RV32E) begin
         for (int p = 0; p < NumWritePorts; p++) begin
            if (we_i[p] && waddr[p][4]) begin
               rng_err = 1'b1;
            end
         end
         for (int k = 0; k < NumReadPorts; k++) begin
            if (raddr[k][4]) begin
               rng_err = 1'b1;
            end
         end
      end
      // A healthy decoder yields at most one bit per port, and only with we
      // high; anything else points at a corrupted enable path.
      if (WrenCheck) begin
         for (int p = 0; p < NumWritePorts; p++) begin
            if (($countones(wr_dec[p]) > 1) || ((|wr_dec[p]) && !we_i[p])) begin
               wren_err = 1'b1;
            end
         end
      end
      err_d = err_q | rng_err | wren_err;
   end

   // ---------------------------------------------------------------------------
   // Clear engine: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         clr_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         err_q     <= err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Clear engine: next state
   // ---------------------------------------------------------------------------
   // Requests outside IDLE are ignored, not queued. Leaving DONE always goes
   // through one IDLE cycle, where a held request starts the next clear.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_req_i) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = 5'd1;
            end
         end
         ST_CLEAR: begin
            if (clr_cnt_q == LastReg) begin
               state_d   = ST_DONE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 5'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            clr_cnt_d = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Clear engine: outputs
   // ---------------------------------------------------------------------------
   // The core is expected to stall while the engine runs, so port writes are
   // only accepted in IDLE.
   always_comb begin
      clr_busy_o = (state_q == ST_CLEAR);
      clr_done_o = (state_q == ST_DONE);
      wr_allowed = (state_q == ST_IDLE);
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// -----------------------------------------------------------------------------
// Testbench for ibex_register_file_mp.
// Two instances: a 32-register build (dut) and an RV32E build (dut_e), both
// with WordZeroVal = 32'hDEAD_BEEF. Expected values come from a behavioural
// model holding plain arrays of register values plus a clear position.
// -----------------------------------------------------------------------------
module tb_ibex_register_file_mp;

   localparam int unsigned DW  = 32;
   localparam int unsigned NR  = 2;
   localparam int unsigned NW  = 2;
   localparam logic [31:0] WZV = 32'hDEAD_BEEF;

   logic              clk;
   logic              rst;

   logic [NR*5-1:0]   raddr;
   logic [NR*DW-1:0]  rdata;
   logic [NW*5-1:0]   waddr;
   logic [NW*DW-1:0]  wdata;
   logic [NW-1:0]     we;
   logic              clr_req;
   logic              clr_busy;
   logic              clr_done;
   logic              err;

   logic [NR*5-1:0]   e_raddr;
   logic [NR*DW-1:0]  e_rdata;
   logic [NW*5-1:0]   e_waddr;
   logic [NW*DW-1:0]  e_wdata;
   logic [NW-1:0]     e_we;
   logic              e_clr_req;
   logic              e_clr_busy;
   logic              e_clr_done;
   logic              e_err;

   // Reference model state.
   logic [31:0]       m_rf [32];
   bit                m_err;
   int                m_clr;   // 0 idle, 1..31 next register to wipe, 32 done
   logic [31:0]       e_rf [16];
   bit                e_m_err;

   int                total;
   int                bad;

   ibex_register_file_mp #(
      .RV32E        (1'b0),
      .DataWidth    (DW),
      .NumReadPorts (NR),
      .NumWritePorts(NW),
      .WrenCheck    (1'b1),
      .WordZeroVal  (WZV)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .raddr_i   (raddr),
      .rdata_o   (rdata),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .we_i      (we),
      .clr_req_i (clr_req),
      .clr_busy_o(clr_busy),
      .clr_done_o(clr_done),
      .err_o     (err)
   );

   ibex_register_file_mp #(
      .RV32E        (1'b1),
      .DataWidth    (DW),
      .NumReadPorts (NR),
      .NumWritePorts(NW),
      .WrenCheck    (1'b0),
      .WordZeroVal  (WZV)
   ) dut_e (
      .clk_i     (clk),
      .rst_i     (rst),
      .raddr_i   (e_raddr),
      .rdata_o   (e_rdata),
      .waddr_i   (e_waddr),
      .wdata_i   (e_wdata),
      .we_i      (e_we),
      .clr_req_i (e_clr_req),
      .clr_busy_o(e_clr_busy),
      .clr_done_o(e_clr_done),
      .err_o     (e_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   task automatic model_step();
      logic [4:0] a;
      if (rst) begin
         for (int r = 0; r < 32; r++) m_rf[r] = WZV;
         for (int r = 0; r < 16; r++) e_rf[r] = WZV;
         m_err   = 1'b0;
         e_m_err = 1'b0;
         m_clr   = 0;
      end else begin
         if (m_clr == 0) begin
            for (int p = 0; p < NW; p++) begin
               a = waddr[p*5 +: 5];
               if (we[p] && a != 5'd0) m_rf[a] = wdata[p*DW +: DW];
            end
         end
         if (m_clr == 0) begin
            if (clr_req) m_clr = 1;
         end else if (m_clr < 32) begin
            m_rf[m_clr] = WZV;
            m_clr++;
         end else begin
            m_clr = 0;
         end

         for (int p = 0; p < NW; p++) begin
            a = e_waddr[p*5 +: 5];
            if (e_we[p]) begin
               if (a[4]) e_m_err = 1'b1;
               else if (a != 5'd0) e_rf[a[3:0]] = e_wdata[p*DW +: DW];
            end
         end
         for (int k = 0; k < NR; k++) begin
            if (e_raddr[k*5 + 4]) e_m_err = 1'b1;
         end
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] v;
      if (a == 5'd0) return 32'h0;
      v = m_rf[a];
`ifdef IBEX_RF_BYPASS_EN
      if (m_clr == 0) begin
         for (int p = 0; p < NW; p++) begin
            if (we[p] && waddr[p*5 +: 5] == a) v = wdata[p*DW +: DW];
         end
      end
`endif
      return v;
   endfunction

   function automatic logic [31:0] e_exp_rd(input logic [4:0] a);
      logic [31:0] v;
      if (a == 5'd0 || a[4]) return 32'h0;
      v = e_rf[a[3:0]];
`ifdef IBEX_RF_BYPASS_EN
      for (int p = 0; p < NW; p++) begin
         if (e_we[p] && e_waddr[p*5 +: 5] == a) v = e_wdata[p*DW +: DW];
      end
`endif
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      logic [31:0] want0, want1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (err !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: got err=%b busy=%b done=%b, want 0 0 0", err, clr_busy, clr_done);
      end
      total++;
      if (e_err !== 1'b0 || e_clr_busy !== 1'b0 || e_clr_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs_e: got err=%b busy=%b done=%b, want 0 0 0", e_err, e_clr_busy, e_clr_done);
      end
      for (int a = 0; a < 32; a++) begin
         raddr = {5'(31 - a), 5'(a)};
         #1;
         want0 = (a == 0)  ? 32'h0 : WZV;
         want1 = (a == 31) ? 32'h0 : WZV;
         total++;
         if (rdata[31:0] !== want0 || rdata[63:32] !== want1) begin
            bad++;
            $display("FAIL reset_read x%0d/x%0d: got %h/%h want %h/%h", a, 31 - a, rdata[31:0], rdata[63:32], want0, want1);
         end
      end
      for (int a = 0; a < 16; a++) begin
         e_raddr = {5'd0, 5'(a)};
         #1;
         want0 = (a == 0) ? 32'h0 : WZV;
         total++;
         if (e_rdata[31:0] !== want0) begin
            bad++;
            $display("FAIL reset_read_e x%0d: got %h want %h", a, e_rdata[31:0], want0);
         end
      end
      e_raddr = '0;
   endtask

   task automatic test_collision();
      we    = 2'b11;
      waddr = {5'd5, 5'd5};
      wdata = {32'h0000_ABCD, 32'h0000_1234};
      tick();
      we    = 2'b00;
      raddr = {5'd5, 5'd5};
      #1;
      total++;
      if (rdata[31:0] !== 32'h0000_ABCD || rdata[63:32] !== 32'h0000_ABCD) begin
         bad++;
         $display("FAIL collision x5: got %h/%h want 0000abcd", rdata[31:0], rdata[63:32]);
      end
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL collision_err: got %b want 0", err);
      end
   endtask

   task automatic test_x0();
      we    = 2'b01;
      waddr = {5'd0, 5'd0};
      wdata = {32'h0, 32'hFFFF_FFFF};
      raddr = {5'd0, 5'd0};
      #1;
      total++;
      if (rdata[31:0] !== 32'h0) begin
         bad++;
         $display("FAIL x0_same_cycle: got %h want 0", rdata[31:0]);
      end
      tick();
      we = 2'b00;
      #1;
      total++;
      if (rdata[31:0] !== 32'h0 || rdata[63:32] !== 32'h0 || err !== 1'b0) begin
         bad++;
         $display("FAIL x0_write: got %h/%h err=%b want 0/0 err=0", rdata[31:0], rdata[63:32], err);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] want;
      we    = 2'b01;
      waddr = {5'd0, 5'd7};
      wdata = {32'h0, 32'h0000_0011};
      tick();
      wdata = {32'h0, 32'h0000_0055};
      raddr = {5'd7, 5'd0};
      #1;
`ifdef IBEX_RF_BYPASS_EN
      want = 32'h0000_0055;
`else
      want = 32'h0000_0011;
`endif
      total++;
      if (rdata[63:32] !== want) begin
         bad++;
         $display("FAIL bypass_same_cycle x7: got %h want %h", rdata[63:32], want);
      end
      tick();
      we = 2'b00;
      #1;
      total++;
      if (rdata[63:32] !== 32'h0000_0055) begin
         bad++;
         $display("FAIL bypass_next_cycle x7: got %h want 00000055", rdata[63:32]);
      end
   endtask

   task automatic test_random();
      logic [31:0] want;
      for (int c = 0; c < 300; c++) begin
         for (int p = 0; p < NW; p++) begin
            we[p]             = ($urandom_range(0, 2) != 0);
            waddr[p*5 +: 5]   = 5'($urandom_range(0, 31));
            wdata[p*DW +: DW] = $urandom;
         end
         if ($urandom_range(0, 3) == 0) waddr[9:5] = waddr[4:0];
         for (int k = 0; k < NR; k++) begin
            raddr[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? waddr[4:0] : 5'($urandom_range(0, 31));
         end
         #1;
         for (int k = 0; k < NR; k++) begin
            want = exp_rd(raddr[k*5 +: 5]);
            total++;
            if (rdata[k*DW +: DW] !== want) begin
               bad++;
               $display("FAIL random_read c=%0d port%0d x%0d: got %h want %h", c, k, raddr[k*5 +: 5], rdata[k*DW +: DW], want);
            end
         end
         tick();
         total++;
         if (err !== m_err || clr_busy !== 1'b0) begin
            bad++;
            $display("FAIL random_status c=%0d: got err=%b busy=%b want err=%b busy=0", c, err, clr_busy, m_err);
         end
      end
      we = '0;
   endtask

   task automatic test_clear();
      int          busy_n;
      int          done_n;
      logic [31:0] want;
      for (int i = 1; i < 32; i++) begin
         we    = 2'b01;
         waddr = {5'd0, 5'(i)};
         wdata = {32'h0, 32'(i)};
         tick();
      end
      we      = '0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      busy_n  = 0;
      done_n  = 0;
      for (int c = 0; c < 40; c++) begin
         we    = '0;
         raddr = {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))};
         if (c == 3) begin
            we    = 2'b01;
            waddr = {5'd0, 5'd9};
            wdata = {32'h0, 32'h0000_0009};
         end
         if (c == 5) begin
            we    = 2'b10;
            waddr = {5'd20, 5'd0};
            wdata = {32'h1234_5678, 32'h0};
         end
         if (c == 6) raddr[4:0] = 5'd20;
         #1;
         if (clr_busy === 1'b1) busy_n++;
         if (clr_done === 1'b1) done_n++;
         total++;
         if (clr_busy !== (m_clr >= 1 && m_clr <= 31) || clr_done !== (m_clr == 32)) begin
            bad++;
            $display("FAIL clear_status c=%0d: got busy=%b done=%b pos=%0d", c, clr_busy, clr_done, m_clr);
         end
         for (int k = 0; k < NR; k++) begin
            want = exp_rd(raddr[k*5 +: 5]);
            total++;
            if (rdata[k*DW +: DW] !== want) begin
               bad++;
               $display("FAIL clear_read c=%0d port%0d x%0d: got %h want %h", c, k, raddr[k*5 +: 5], rdata[k*DW +: DW], want);
            end
         end
         if (c == 6) begin
            total++;
            if (rdata[31:0] !== 32'd20) begin
               bad++;
               $display("FAIL clear_drop x20: got %h want 00000014", rdata[31:0]);
            end
         end
         tick();
      end
      total++;
      if (busy_n != 31 || done_n != 1) begin
         bad++;
         $display("FAIL clear_length: got busy=%0d done=%0d want busy=31 done=1", busy_n, done_n);
      end
      for (int a = 1; a < 32; a++) begin
         raddr = {5'd0, 5'(a)};
         #1;
         total++;
         if (rdata[31:0] !== WZV) begin
            bad++;
            $display("FAIL clear_result x%0d: got %h want %h", a, rdata[31:0], WZV);
         end
      end
   endtask

   task automatic test_clear_hold();
      logic exp_busy, exp_done;
      clr_req = 1'b1;
      for (int n = 1; n <= 36; n++) begin
         tick();
         exp_busy = (n <= 31) || (n >= 34);
         exp_done = (n == 32);
         total++;
         if (clr_busy !== exp_busy || clr_done !== exp_done) begin
            bad++;
            $display("FAIL clear_hold n=%0d: got busy=%b done=%b want busy=%b done=%b", n, clr_busy, clr_done, exp_busy, exp_done);
         end
      end
      clr_req = 1'b0;
   endtask

   task automatic test_reset_mid_clear();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
         bad++;
         $display("FAIL abort_hold: got busy=%b done=%b want 0 0", clr_busy, clr_done);
      end
      we    = 2'b01;
      waddr = {5'd0, 5'd30};
      wdata = {32'h0, 32'h0000_0030};
      tick();
      we      = '0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
      tick();
      total++;
      if (clr_busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_clear_busy: got %b want 1", clr_busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         total++;
         if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_clear_reset c=%0d: got busy=%b done=%b want 0 0", c, clr_busy, clr_done);
         end
         tick();
      end
      for (int a = 1; a < 32; a++) begin
         raddr = {5'd0, 5'(a)};
         #1;
         total++;
         if (rdata[31:0] !== WZV) begin
            bad++;
            $display("FAIL mid_clear_regs x%0d: got %h want %h", a, rdata[31:0], WZV);
         end
      end
   endtask

   task automatic test_rv32e();
      logic [31:0] want;
      // In-range random traffic first: no error may appear.
      for (int c = 0; c < 60; c++) begin
         for (int p = 0; p < NW; p++) begin
            e_we[p]             = ($urandom_range(0, 1) != 0);
            e_waddr[p*5 +: 5]   = 5'($urandom_range(0, 15));
            e_wdata[p*DW +: DW] = $urandom;
         end
         for (int k = 0; k < NR; k++) e_raddr[k*5 +: 5] = 5'($urandom_range(0, 15));
         #1;
         for (int k = 0; k < NR; k++) begin
            want = e_exp_rd(e_raddr[k*5 +: 5]);
            total++;
            if (e_rdata[k*DW +: DW] !== want) begin
               bad++;
               $display("FAIL e_random_read c=%0d port%0d x%0d: got %h want %h", c, k, e_raddr[k*5 +: 5], e_rdata[k*DW +: DW], want);
            end
         end
         tick();
         total++;
         if (e_err !== e_m_err) begin
            bad++;
            $display("FAIL e_random_err c=%0d: got %b want %b", c, e_err, e_m_err);
         end
      end
      e_we = '0;

      // Out-of-range write: dropped, error sticky until reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      e_we    = 2'b01;
      e_waddr = {5'd0, 5'd20};
      e_wdata = {32'h0, 32'h0000_0001};
      e_raddr = {5'd20, 5'd4};
      #1;
      total++;
      if (e_rdata[31:0] !== WZV || e_rdata[63:32] !== 32'h0) begin
         bad++;
         $display("FAIL e_oor_write_same_cycle: got x4=%h x20=%h want %h 0", e_rdata[31:0], e_rdata[63:32], WZV);
      end
      tick();
      e_we    = '0;
      e_raddr = {5'd0, 5'd4};
      for (int c = 0; c < 4; c++) begin
         #1;
         total++;
         if (e_err !== 1'b1 || e_rdata[31:0] !== WZV) begin
            bad++;
            $display("FAIL e_oor_write c=%0d: got err=%b x4=%h want err=1 x4=%h", c, e_err, e_rdata[31:0], WZV);
         end
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (e_err !== 1'b0) begin
         bad++;
         $display("FAIL e_err_reset: got %b want 0", e_err);
      end

      // Out-of-range read: returns 0 and raises the error.
      e_raddr = {5'd17, 5'd0};
      #1;
      total++;
      if (e_rdata[63:32] !== 32'h0) begin
         bad++;
         $display("FAIL e_oor_read: got %h want 0", e_rdata[63:32]);
      end
      tick();
      e_raddr = '0;
      #1;
      total++;
      if (e_err !== 1'b1) begin
         bad++;
         $display("FAIL e_oor_read_err: got %b want 1", e_err);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (e_err !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL final_reset_err: got e_err=%b err=%b want 0 0", e_err, err);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence
   // ---------------------------------------------------------------------------
   initial begin
      total     = 0;
      bad       = 0;
      m_clr     = 0;
      m_err     = 1'b0;
      e_m_err   = 1'b0;
      rst       = 1'b1;
      raddr     = '0;
      waddr     = '0;
      wdata     = '0;
      we        = '0;
      clr_req   = 1'b0;
      e_raddr   = '0;
      e_waddr   = '0;
      e_wdata   = '0;
      e_we      = '0;
      e_clr_req = 1'b0;

      test_reset();
      test_collision();
      test_x0();
      test_bypass();
      test_random();
      test_clear();
      test_clear_hold();
      test_reset_mid_clear();
      test_rv32e();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
